fsqrt_seq: RTL and testbench
============================

# fsqrt_seq

Issue/retire sequencer for the split single-precision square-root datapath (five stages; final stage combines exponent and mantissa). Accepts operands with a valid/ready handshake and drives the datapath's common stage-advance enable. Carries a destination tag and valid bit alongside each operand and retires results in order through a one-entry output register with backpressure. Sits between the FPU dispatch logic and the writeback arbiter.

## Interface
- LAT, 5, number of datapath register stages between `dp_x` and `dp_y` (≥2)
- TAGW, 6, width of the destination tag

- clk  in  1  clock
- rstn  in  1  synchronous active-low reset
- req_valid  in  1  operand offered
- req_ready  out  1  operand accepted this cycle when high with req_valid
- req_x  in  32  IEEE-754 single operand
- req_tag  in  TAGW  destination tag
- flush  in  1  kill all in-flight and held operations
- dp_x  out  32  operand to datapath stage 1 (combinational = req_x)
- dp_adv  out  1  enable for every datapath inter-stage register
- dp_y  in  32  combinational result of the last datapath stage
- res_valid  out  1  result held
- res_ready  in  1  consumer takes result
- res_y  out  32  result
- res_tag  out  TAGW  tag of result
- res_nv  out  1  invalid-operation flag
- busy  out  1  inflight != 0
- inflight  out  $clog2(LAT+2)  operations accepted and not yet retired or flushed

## Operation
- dp_adv = !(res_valid && !res_ready); req_ready = dp_adv && !flush.
- accept = req_valid && req_ready.
- Shadow pipe v[0..LAT-1], tag[0..LAT-1]: on dp_adv, v[0]<=accept, tag[0]<=req_tag, v[i]<=v[i-1]. When dp_adv is low, the pipe holds.
- Retire capture: on dp_adv, res_valid<=v[LAT-1]; if v[LAT-1], then res_y<=dp_y (or the special override) and res_tag<=tag[LAT-1].
- Bubbles do not collapse; the whole pipe stalls only while the output is full and not drained.
- inflight: +1 on accept, −1 on res_valid&&res_ready; both in the same cycle → unchanged. Maximum LAT+1.
- flush: at the next edge clear all v[], res_valid and inflight to 0. Captured res_y/res_tag values are don't-care. A request in the flush cycle is not accepted.
- rstn low: v[] = 0, res_valid = 0, res_y = 0, res_tag = 0, res_nv = 0, inflight = 0. Reset overrides flush and any handshake, including mid-operation.

## Timing
- Request accepted in cycle 0 → v[0] in cycle 1 → v[LAT-1] in cycle LAT → res_valid in cycle LAT+1 (6 at default).
- Throughput is one per cycle while res_ready is held high.
- res_ready low with res_valid high freezes the pipe and res_* exactly; the next dp_adv resumes with no loss or duplication.
- Results retire in acceptance order.

## Configuration
- FSQRT_SPECIAL_EN defined: each operand is classified at accept, and a 3-bit class and sign travel with v[]. The class overrides dp_y at capture:
  - exponent 0 → {sign, 31'b0}, nv = 0
  - negative non-zero, non-NaN → 0x7FC00000, nv = 1
  - +inf → 0x7F800000
  - NaN → 0x7FC00000, nv = 0
  - all other operands use dp_y.
- FSQRT_SPECIAL_EN undefined: res_y = captured dp_y, res_nv is tied to 0, and no class registers are built.

## Test plan
- Single op 0x40800000 (4.0), tag 5, res_ready = 1 → res_valid only in cycle 6 with res_y 0x40000000, res_tag 5; inflight 1 in cycles 1–6, then 0.
- 8 back-to-back ops (tags 0–7), res_ready = 1 → results in cycles 6–13, tags in order, req_ready always 1.
- Pipe full (6 in flight), res_ready low 3 cycles → req_ready and dp_adv low for those 3 cycles, res_* stable, inflight stays 6; all 6 results then retire in order.
- 3 ops in flight, flush for 1 cycle with req_valid high → no res_valid afterwards, inflight 0. The next op accepted after flush retires 6 cycles later.
- With FSQRT_SPECIAL_EN: 0xC0800000 → 0x7FC00000, nv = 1; 0x80000000 → 0x80000000, nv = 0; 0x7F800000 → 0x7F800000. Without the macro, res_nv is 0 for all three.
- rstn low for 1 cycle with 4 ops in flight and res_valid high → all outputs 0 next cycle; no stale result appears later.

Source files
------------

// File: rtl/fsqrt_seq.sv
// fsqrt_seq: issue/retire sequencer for the five-stage sqrt datapath.
// Optional macro FSQRT_SPECIAL_EN: carry an operand class and override specials.
module fsqrt_seq #(
    parameter int LAT  = 5,
    parameter int TAGW = 6
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [31:0]               req_x,
    input  logic [TAGW-1:0]           req_tag,
    input  logic                      flush,
    output logic [31:0]               dp_x,
    output logic                      dp_adv,
    input  logic [31:0]               dp_y,
    output logic                      res_valid,
    input  logic                      res_ready,
    output logic [31:0]               res_y,
    output logic [TAGW-1:0]           res_tag,
    output logic                      res_nv,
    output logic                      busy,
    output logic [$clog2(LAT+2)-1:0]  inflight
);

    localparam int CW = $clog2(LAT + 2);

    logic [LAT-1:0]  v;
    logic [TAGW-1:0] tag [LAT];
    logic            accept;
    logic            retire;
    logic [31:0]     cap_y;

    assign dp_adv    = !(res_valid && !res_ready);
    assign req_ready = dp_adv && !flush;
    assign accept    = req_valid && req_ready;
    assign retire    = res_valid && res_ready;
    assign dp_x      = req_x;
    assign busy      = (inflight != '0);

    // valid shadow pipe, moves in lockstep with the datapath
    always_ff @(posedge clk) begin
        if (!rstn) begin
            v <= '0;
        end else if (flush) begin
            v <= '0;
        end else if (dp_adv) begin
            v <= {v[LAT-2:0], accept};
        end
    end

    // tag shadow pipe, payload only so no reset
    always_ff @(posedge clk) begin
        if (dp_adv) begin
            tag[0] <= req_tag;
            for (int i = 1; i < LAT; i++) begin
                tag[i] <= tag[i-1];
            end
        end
    end

`ifdef FSQRT_SPECIAL_EN
    typedef enum logic [2:0] {
        C_NORM,
        C_ZERO,
        C_NEG,
        C_INF,
        C_NAN
    } cls_t;

    cls_t cls_in;
    cls_t cls [LAT];
    logic sgn [LAT];
    logic cap_nv;

    // classify the operand at issue; NaN wins over the sign test
    always_comb begin
        cls_in = C_NORM;
        if (req_x[30:23] == 8'h00) begin
            cls_in = C_ZERO;
        end else if (req_x[30:23] == 8'hFF && req_x[22:0] != '0) begin
            cls_in = C_NAN;
        end else if (req_x[31]) begin
            cls_in = C_NEG;
        end else if (req_x[30:23] == 8'hFF) begin
            cls_in = C_INF;
        end
    end

    // class and sign travel alongside the valid bits
    always_ff @(posedge clk) begin
        if (dp_adv) begin
            cls[0] <= cls_in;
            sgn[0] <= req_x[31];
            for (int i = 1; i < LAT; i++) begin
                cls[i] <= cls[i-1];
                sgn[i] <= sgn[i-1];
            end
        end
    end

    // replace the datapath result for special operands
    always_comb begin
        cap_y  = dp_y;
        cap_nv = 1'b0;
        unique case (cls[LAT-1])
            C_ZERO: cap_y = {sgn[LAT-1], 31'b0};
            C_NEG: begin
                cap_y  = 32'h7FC0_0000;
                cap_nv = 1'b1;
            end
            C_INF:  cap_y = 32'h7F80_0000;
            C_NAN:  cap_y = 32'h7FC0_0000;
            default: ;
        endcase
    end

    // invalid flag is captured with the result
    always_ff @(posedge clk) begin
        if (!rstn) begin
            res_nv <= 1'b0;
        end else if (!flush && dp_adv && v[LAT-1]) begin
            res_nv <= cap_nv;
        end
    end
`else
    assign cap_y  = dp_y;
    assign res_nv = 1'b0;
`endif

    // one-entry output register; holds while the consumer stalls
    always_ff @(posedge clk) begin
        if (!rstn) begin
            res_valid <= 1'b0;
            res_y     <= '0;
            res_tag   <= '0;
        end else if (flush) begin
            res_valid <= 1'b0;
        end else if (dp_adv) begin
            res_valid <= v[LAT-1];
            if (v[LAT-1]) begin
                res_y   <= cap_y;
                res_tag <= tag[LAT-1];
            end
        end
    end

    // count of accepted but not yet retired operations
    always_ff @(posedge clk) begin
        if (!rstn) begin
            inflight <= '0;
        end else if (flush) begin
            inflight <= '0;
        end else begin
            inflight <= inflight + CW'(accept) - CW'(retire);
        end
    end

endmodule

// File: tb/tb_fsqrt_seq.sv
// tb_fsqrt_seq: bench for fsqrt_seq with a stub datapath and scoreboard.
// Build with FSQRT_SPECIAL_EN defined to check the special-operand path.
module tb_fsqrt_seq;

    localparam int LAT  = 5;
    localparam int TAGW = 6;
    localparam int CW   = $clog2(LAT + 2);

    logic            clk = 1'b0;
    logic            rstn;
    logic            req_valid;
    logic            req_ready;
    logic [31:0]     req_x;
    logic [TAGW-1:0] req_tag;
    logic            flush;
    logic [31:0]     dp_x;
    logic            dp_adv;
    logic [31:0]     dp_y;
    logic            res_valid;
    logic            res_ready;
    logic [31:0]     res_y;
    logic [TAGW-1:0] res_tag;
    logic            res_nv;
    logic            busy;
    logic [CW-1:0]   inflight;

    always #5 clk = ~clk;

    fsqrt_seq #(.LAT(LAT), .TAGW(TAGW)) dut (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_x(req_x), .req_tag(req_tag), .flush(flush),
        .dp_x(dp_x), .dp_adv(dp_adv), .dp_y(dp_y),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_y(res_y), .res_tag(res_tag), .res_nv(res_nv),
        .busy(busy), .inflight(inflight)
    );

    // stub datapath: a few true roots, otherwise a recognisable scramble
    function automatic logic [31:0] dpf(input logic [31:0] x);
        case (x)
            32'h4080_0000: return 32'h4000_0000;
            32'h4110_0000: return 32'h4040_0000;
            32'h3F80_0000: return 32'h3F80_0000;
            32'h4180_0000: return 32'h4080_0000;
            32'h42C8_0000: return 32'h4120_0000;
            default:       return x ^ 32'h0F0F_0F0F;
        endcase
    endfunction

    logic [31:0] d [LAT];
    always @(posedge clk) begin
        if (dp_adv) begin
            d[0] <= dp_x;
            for (int i = 1; i < LAT; i++) d[i] <= d[i-1];
        end
    end
    assign dp_y = dpf(d[LAT-1]);

    typedef struct {
        logic [31:0]     y;
        logic [TAGW-1:0] tag;
        logic            nv;
        int              cnt;
        int              acyc;
    } exp_t;

    typedef struct {
        logic [31:0] x;
        logic [31:0] y_dp;
        logic [31:0] y_sp;
        logic        nv_sp;
    } vec_t;

    exp_t q[$];
    vec_t tv[12];
    int n_vec = 0;
    int n_bad = 0;
    int mif = 0;
    int cyc = 0;
    int n_ret = 0;
    int last_lat = 0;
    int lat_min = 0;
    int lat_max = 0;
    logic [31:0] cur_y;
    logic        cur_nv;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // one clock: check against the model, advance model across the edge
    task automatic step(output bit acc);
        bit erv;
        bit eadv;
        bit ret;
        #1;
        erv  = (q.size() > 0) && (q[0].cnt == 0);
        eadv = !(erv && !res_ready);
        if (rstn) begin
            chk("res_valid", res_valid, erv);
            chk("dp_adv", dp_adv, eadv);
            chk("req_ready", req_ready, eadv && !flush);
            chk("inflight", inflight, mif);
            chk("busy", busy, mif != 0);
            chk("dp_x", dp_x, req_x);
            if (erv) begin
                chk("res_y", res_y, q[0].y);
                chk("res_tag", res_tag, q[0].tag);
                chk("res_nv", res_nv, q[0].nv);
            end
        end
        acc = rstn && req_valid && eadv && !flush;
        ret = erv && res_ready;
        @(posedge clk);
        if (!rstn || flush) begin
            q.delete();
            mif = 0;
            acc = 1'b0;
        end else begin
            if (eadv) begin
                foreach (q[i]) if (q[i].cnt > 0) q[i].cnt = q[i].cnt - 1;
            end
            if (ret) begin
                last_lat = cyc - q[0].acyc;
                if (last_lat < lat_min) lat_min = last_lat;
                if (last_lat > lat_max) lat_max = last_lat;
                n_ret++;
                void'(q.pop_front());
                mif--;
            end
            if (acc) begin
                q.push_back('{y: cur_y, tag: req_tag, nv: cur_nv,
                              cnt: LAT, acyc: cyc});
                mif++;
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic drive(input bit vld, input logic [31:0] x,
                         input logic [TAGW-1:0] t, input logic [31:0] ey,
                         input bit en, input bit rr, output bit acc);
        req_valid = vld;
        req_x     = x;
        req_tag   = t;
        cur_y     = ey;
        cur_nv    = en;
        res_ready = rr;
        step(acc);
    endtask

    task automatic idle(input int n, input bit rr);
        bit a;
        for (int i = 0; i < n; i++) drive(1'b0, 32'h0, '0, 32'h0, 1'b0, rr, a);
    endtask

    task automatic lat_reset();
        lat_min = 1000;
        lat_max = 0;
    endtask

    initial begin
        bit a;
        int base;
        logic [31:0] x;
        logic [31:0] ey;
        bit en;

        tv[0]  = '{32'h4080_0000, 32'h4000_0000, 32'h4000_0000, 1'b0};
        tv[1]  = '{32'h4110_0000, 32'h4040_0000, 32'h4040_0000, 1'b0};
        tv[2]  = '{32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 1'b0};
        tv[3]  = '{32'h4180_0000, 32'h4080_0000, 32'h4080_0000, 1'b0};
        tv[4]  = '{32'h42C8_0000, 32'h4120_0000, 32'h4120_0000, 1'b0};
        tv[5]  = '{32'hC080_0000, 32'hCF8F_0F0F, 32'h7FC0_0000, 1'b1};
        tv[6]  = '{32'h8000_0000, 32'h8F0F_0F0F, 32'h8000_0000, 1'b0};
        tv[7]  = '{32'h7F80_0000, 32'h708F_0F0F, 32'h7F80_0000, 1'b0};
        tv[8]  = '{32'h7FC0_0001, 32'h70CF_0F0E, 32'h7FC0_0000, 1'b0};
        tv[9]  = '{32'h0000_0001, 32'h0F0F_0F0E, 32'h0000_0000, 1'b0};
        tv[10] = '{32'hFF80_0000, 32'hF08F_0F0F, 32'h7FC0_0000, 1'b1};
        tv[11] = '{32'hFFC0_0000, 32'hF0CF_0F0F, 32'h7FC0_0000, 1'b0};

        rstn = 1'b0;
        flush = 1'b0;
        req_valid = 1'b0;
        req_x = '0;
        req_tag = '0;
        res_ready = 1'b1;
        cur_y = '0;
        cur_nv = 1'b0;
        @(negedge clk);
        idle(2, 1'b1);
        rstn = 1'b1;
        #1;
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_y", res_y, 0);
        chk("rst_res_tag", res_tag, 0);
        chk("rst_res_nv", res_nv, 0);
        chk("rst_inflight", inflight, 0);
        chk("rst_busy", busy, 0);
        chk("rst_req_ready", req_ready, 1);

        // single operation, latency LAT+1
        lat_reset();
        base = n_ret;
        drive(1'b1, 32'h4080_0000, 6'd5, 32'h4000_0000, 1'b0, 1'b1, a);
        idle(10, 1'b1);
        chk("t1_count", n_ret - base, 1);
        chk("t1_lat", last_lat, LAT + 1);

        // eight back-to-back operations
        lat_reset();
        base = n_ret;
        for (int i = 0; i < 8; i++) begin
            x = 32'h4040_0000 + i;
            drive(1'b1, x, TAGW'(i), dpf(x), 1'b0, 1'b1, a);
            chk("t2_accept", a, 1);
        end
        idle(12, 1'b1);
        chk("t2_count", n_ret - base, 8);
        chk("t2_lat_min", lat_min, LAT + 1);
        chk("t2_lat_max", lat_max, LAT + 1);

        // fill the pipe, then hold the consumer off for three cycles
        base = n_ret;
        for (int i = 0; i < LAT + 1; i++) begin
            x = 32'h4100_0000 + 16 * i;
            drive(1'b1, x, TAGW'(20 + i), dpf(x), 1'b0, 1'b1, a);
        end
        #1;
        res_ready = 1'b0;
        #1;
        chk("t3_full_inflight", inflight, LAT + 1);
        chk("t3_full_adv", dp_adv, 0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h4500_0000, 6'd63, 32'h0, 1'b0, 1'b0, a);
            chk("t3_stall_noacc", a, 0);
        end
        idle(12, 1'b1);
        chk("t3_count", n_ret - base, LAT + 1);

        // flush with three in flight and a request offered
        base = n_ret;
        for (int i = 0; i < 3; i++) begin
            x = 32'h4200_0000 + i;
            drive(1'b1, x, TAGW'(40 + i), dpf(x), 1'b0, 1'b1, a);
        end
        flush = 1'b1;
        drive(1'b1, 32'h4210_0000, 6'd50, 32'h0, 1'b0, 1'b1, a);
        flush = 1'b0;
        idle(8, 1'b1);
        chk("t4_flushed_count", n_ret - base, 0);
        chk("t4_inflight", inflight, 0);
        lat_reset();
        drive(1'b1, 32'h4110_0000, 6'd51, 32'h4040_0000, 1'b0, 1'b1, a);
        idle(8, 1'b1);
        chk("t4_after_count", n_ret - base, 1);
        chk("t4_after_lat", last_lat, LAT + 1);

        // table vectors with random backpressure
        base = n_ret;
        for (int i = 0; i < 12; i++) begin
`ifdef FSQRT_SPECIAL_EN
            ey = tv[i].y_sp;
            en = tv[i].nv_sp;
`else
            ey = tv[i].y_dp;
            en = 1'b0;
`endif
            a = 1'b0;
            for (int k = 0; k < 20 && !a; k++) begin
                drive(1'b1, tv[i].x, TAGW'(3 + 5 * i), ey, en,
                      1'($urandom_range(0, 3) != 0), a);
            end
            chk("t5_accepted", a, 1);
        end
        idle(20, 1'b1);
        chk("t5_count", n_ret - base, 12);

        // reset mid-operation with a held result
        base = n_ret;
        for (int i = 0; i < 4; i++) begin
            x = 32'h4300_0000 + i;
            drive(1'b1, x, TAGW'(60 + i), dpf(x), 1'b0, 1'b1, a);
        end
        idle(2, 1'b1);
        res_ready = 1'b0;
        #1;
        chk("t6_pre_valid", res_valid, 1);
        chk("t6_pre_inflight", inflight, 4);
        rstn = 1'b0;
        drive(1'b0, 32'h0, '0, 32'h0, 1'b0, 1'b0, a);
        rstn = 1'b1;
        #1;
        chk("t6_res_valid", res_valid, 0);
        chk("t6_res_y", res_y, 0);
        chk("t6_res_tag", res_tag, 0);
        chk("t6_res_nv", res_nv, 0);
        chk("t6_inflight", inflight, 0);
        chk("t6_busy", busy, 0);
        idle(10, 1'b1);
        chk("t6_count", n_ret - base, 0);

        chk("final_queue_empty", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
